// File: rtl/alsu_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alsu_seq_ctrl_pkg
// Shared definitions for the ALSU sequencing controller:
//   - cmd_op encodings (SHLV, SHRV, MUL, reserved)
//   - FSM state enum
//   - opcodes understood by the shared ALSU (ADD, SLL-by-1, SRL-by-1)
// Configuration macro: ALSU_SEQ_MUL_EN (enables the multiply command).
// ---------------------------------------------------------------------------
package alsu_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_SHLV = 2'b00,
    OP_SHRV = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT     = 3'd1,
    ST_MUL_ADD   = 3'd2,
    ST_MUL_SHIFT = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

endpackage

// File: rtl/alsu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alsu_seq_ctrl
// Multi-cycle command sequencer driving a shared, externally instantiated
// ALSU. Variable shifts are built from repeated shift-by-1 operations;
// multiply (optional) is shift-and-add.
//
// Configuration macro: ALSU_SEQ_MUL_EN
//   defined   -> cmd_op 10 performs MUL (low BUS_WIDTH bits of a*b)
//   undefined -> MUL logic absent; cmd_op 10 answers with rsp_err = 1
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op, cmd_a, cmd_b  command opcode and operands
//   rsp_valid/rsp_ready   response handshake (valid only in DONE)
//   rsp_result/zero/err   response payload, stable while rsp_valid
//   alu_Op, alu_A, alu_B  request to the shared ALSU
//   alus_result, zero_flag  ALSU answer (combinational, same cycle)
//   busy                  high in every state except IDLE
// ---------------------------------------------------------------------------
module alsu_seq_ctrl
  import alsu_seq_ctrl_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [BUS_WIDTH-1:0] cmd_a,
  input  logic [BUS_WIDTH-1:0] cmd_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BUS_WIDTH-1:0] rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_err,
  output logic [2:0]           alu_Op,
  output logic [BUS_WIDTH-1:0] alu_A,
  output logic [BUS_WIDTH-1:0] alu_B,
  input  logic [BUS_WIDTH-1:0] alus_result,
  input  logic                 zero_flag,
  output logic                 busy
);

  localparam int unsigned SAW = $clog2(BUS_WIDTH);

  state_e               state_q;
  logic [BUS_WIDTH-1:0] acc_q;   // shift accumulator; doubles as product for MUL
  logic [SAW-1:0]       cnt_q;
  logic                 dir_q;   // 1 = shift right
  logic                 zero_q;
  logic                 err_q;

`ifdef ALSU_SEQ_MUL_EN
  logic [BUS_WIDTH-1:0] m_q;
  logic [BUS_WIDTH-1:0] q_q;
  logic [BUS_WIDTH-1:0] q_d;

  assign q_d = q_q >> 1;
`else
  logic unused_cmd_b;
  assign unused_cmd_b = ^cmd_b[BUS_WIDTH-1:SAW];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALSU_SEQ_MUL_EN
      m_q     <= '0;
      q_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            err_q <= 1'b0;
            case (cmd_op)
              OP_SHLV, OP_SHRV: begin
                dir_q <= cmd_op[0];
                acc_q <= cmd_a;
                cnt_q <= cmd_b[SAW-1:0];
                if (cmd_b[SAW-1:0] == '0) begin
                  // no ALSU pass, so the zero flag comes from the operand
                  zero_q  <= (cmd_a == '0);
                  state_q <= ST_DONE;
                end else begin
                  state_q <= ST_SHIFT;
                end
              end
`ifdef ALSU_SEQ_MUL_EN
              OP_MUL: begin
                acc_q <= '0;
                m_q   <= cmd_a;
                q_q   <= cmd_b;
                if (cmd_b == '0) begin
                  zero_q  <= 1'b1;
                  state_q <= ST_DONE;
                end else begin
                  state_q <= ST_MUL_ADD;
                end
              end
`endif
              default: begin
                acc_q   <= '0;
                zero_q  <= 1'b1;
                err_q   <= 1'b1;
                state_q <= ST_DONE;
              end
            endcase
          end
        end

        ST_SHIFT: begin
          acc_q  <= alus_result;
          zero_q <= zero_flag;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == SAW'(1)) state_q <= ST_DONE;
        end

`ifdef ALSU_SEQ_MUL_EN
        ST_MUL_ADD: begin
          acc_q   <= alus_result;
          zero_q  <= zero_flag;
          state_q <= ST_MUL_SHIFT;
        end

        ST_MUL_SHIFT: begin
          m_q     <= alus_result;
          q_q     <= q_d;
          zero_q  <= zero_flag;
          state_q <= (q_d != '0) ? ST_MUL_ADD : ST_DONE;
        end
`endif

        ST_DONE: begin
          if (rsp_ready) state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ALSU request is a pure decode of the registered state, idle value ADD 0+0
  always_comb begin
    alu_Op = ALU_ADD;
    alu_A  = '0;
    alu_B  = '0;
    case (state_q)
      ST_SHIFT: begin
        alu_Op = dir_q ? ALU_SRL : ALU_SLL;
        alu_A  = acc_q;
      end
`ifdef ALSU_SEQ_MUL_EN
      ST_MUL_ADD: begin
        alu_Op = ALU_ADD;
        alu_A  = acc_q;
        alu_B  = q_q[0] ? m_q : '0;
      end
      ST_MUL_SHIFT: begin
        alu_Op = ALU_SLL;
        alu_A  = m_q;
      end
`endif
      default: ;
    endcase
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_result = acc_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alsu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alsu_seq_ctrl
// Bench for alsu_seq_ctrl. Provides a behavioural ALSU on the shared port,
// a command-level reference model (result, flags and latency computed
// arithmetically per command), a per-cycle compare process, directed
// literal cases and a randomized phase.
// Honours ALSU_SEQ_MUL_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_alsu_seq_ctrl;

  localparam int W   = 16;
  localparam int SAW = $clog2(W);

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic         rsp_err;
  logic [2:0]   alu_Op;
  logic [W-1:0] alu_A;
  logic [W-1:0] alu_B;
  logic [W-1:0] alus_result;
  logic         zero_flag;
  logic         busy;

  int total = 0;
  int bad   = 0;

  alsu_seq_ctrl #(.BUS_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_err     (rsp_err),
    .alu_Op      (alu_Op),
    .alu_A       (alu_A),
    .alu_B       (alu_B),
    .alus_result (alus_result),
    .zero_flag   (zero_flag),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALSU stand-in
  always_comb begin
    alus_result = '0;
    case (alu_Op)
      3'b000:  alus_result = alu_A + alu_B;
      3'b110:  alus_result = alu_A << 1;
      3'b111:  alus_result = alu_A >> 1;
      default: alus_result = '0;
    endcase
    zero_flag = (alus_result == '0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Command-level prediction: response payload and cycle in which DONE appears
  function automatic void predict(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic z, output logic e, output int lat);
    int n;
    int k;
    logic [2*W-1:0] p;
    logic [W-1:0] t;
    r = '0; z = 1'b1; e = 1'b0; lat = 1;
    case (op)
      2'b00, 2'b01: begin
        n   = int'(b) % W;
        r   = (op == 2'b00) ? (a << n) : (a >> n);
        z   = (r == '0);
        lat = n + 1;
      end
      2'b10: begin
`ifdef ALSU_SEQ_MUL_EN
        if (b != '0) begin
          k = 0;
          for (int unsigned i = 0; i < W; i++) if (b[i]) k = i + 1;
          p   = a * b;
          r   = p[W-1:0];
          // final ALSU pass shifts the multiplicand a left for the k-th time
          t   = a << k;
          z   = (t == '0);
          lat = 2 * k + 1;
        end
`else
        e = 1'b1;
`endif
      end
      default: e = 1'b1;
    endcase
  endfunction

  // Reference model: 0 = idle, 1 = working, 2 = response pending
  int           m_phase;
  int           m_left;
  logic [W-1:0] m_res;
  logic         m_zero;
  logic         m_err;
  int           resp_cnt;

  always @(posedge clk or negedge rst_n) begin : model_blk
    logic [W-1:0] r;
    logic z, e;
    int lat;
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
    end else begin
      case (m_phase)
        0: if (cmd_valid) begin
          predict(cmd_op, cmd_a, cmd_b, r, z, e, lat);
          m_res  <= r;
          m_zero <= z;
          m_err  <= e;
          if (lat == 1) m_phase <= 2;
          else begin
            m_phase <= 1;
            m_left  <= lat - 1;
          end
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_phase <= 2;
        end
        default: if (rsp_ready) begin
          m_phase  <= 0;
          resp_cnt <= resp_cnt + 1;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        chk("rsp_result", 32'(rsp_result), 32'(m_res));
        chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
      end
      if (m_phase != 1) begin
        chk("alu_Op_idle", 32'(alu_Op), 32'd0);
        chk("alu_A_idle", 32'(alu_A), 32'd0);
        chk("alu_B_idle", 32'(alu_B), 32'd0);
      end
    end
  end

  task automatic drain(input string nm);
    int c;
    c = 0;
    while (!rsp_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk({nm, " drain_valid"}, 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Directed command with literal expectations; hold > 0 keeps rsp_ready low
  // that many extra cycles while offering another command (SHLV a<<3).
  task automatic run_cmd(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res,
                         input logic exp_zero, input logic exp_err, input int exp_lat,
                         input int hold);
    int cyc;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({nm, " result"}, 32'(rsp_result), 32'(exp_res));
    chk({nm, " zero"}, 32'(rsp_zero), 32'(exp_zero));
    chk({nm, " err"}, 32'(rsp_err), 32'(exp_err));
    if (hold > 0) begin
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 16'h0011; cmd_b = 16'd3;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({nm, " hold_result"}, 32'(rsp_result), 32'(exp_res));
        chk({nm, " hold_valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, " hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (hold > 0) begin
      chk({nm, " after_hs_ready"}, 32'(cmd_ready), 32'd1);
      chk({nm, " after_hs_busy"}, 32'(busy), 32'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk({nm, " next_accepted"}, 32'(busy), 32'd1);
      drain(nm);
      chk({nm, " next_result"}, 32'(rsp_result), 32'h0088);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish by time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] msk;
    int c;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    resp_cnt = 0;
    repeat (2) @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_result", 32'(rsp_result), 32'd0);
    chk("reset rsp_zero", 32'(rsp_zero), 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset alu", {29'd0, alu_Op} | 32'(alu_A) | 32'(alu_B), 32'd0);
    rst_n = 1'b1;

    run_cmd("shlv_1_4",    2'b00, 16'h0001, 16'd4,  16'h0010, 1'b0, 1'b0, 5,  0);
    run_cmd("shrv_8000_15",2'b01, 16'h8000, 16'd15, 16'h0001, 1'b0, 1'b0, 16, 0);
    run_cmd("shlv_8000_1", 2'b00, 16'h8000, 16'd1,  16'h0000, 1'b1, 1'b0, 2,  0);
    run_cmd("shlv_abcd_0", 2'b00, 16'hABCD, 16'd0,  16'hABCD, 1'b0, 1'b0, 1,  0);
    run_cmd("shrv_0_0",    2'b01, 16'h0000, 16'h0030, 16'h0000, 1'b1, 1'b0, 1, 0);
    run_cmd("rsvd",        2'b11, 16'h5555, 16'h0003, 16'h0000, 1'b1, 1'b1, 1, 0);
`ifdef ALSU_SEQ_MUL_EN
    run_cmd("mul_3_5",     2'b10, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 7,  0);
    run_cmd("mul_b0",      2'b10, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 1,  0);
    run_cmd("mul_ovf",     2'b10, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 19, 0);
`else
    run_cmd("mul_disabled",2'b10, 16'h0003, 16'h0005, 16'h0000, 1'b1, 1'b1, 1,  0);
`endif
    run_cmd("hold_shlv",   2'b00, 16'h0003, 16'd2,  16'h000C, 1'b0, 1'b0, 3,  3);

    // reset in cycle 3 of a long shift
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 16'h0001; cmd_b = 16'd8;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("midreset no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_cmd("after_reset", 2'b00, 16'h0001, 16'd2, 16'h0004, 1'b0, 1'b0, 3, 0);

    // randomized traffic, model and compare process do the checking
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 9) < 7);
      cmd_op    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       cmd_a = '0;
        1:       cmd_a = 16'h8000;
        2:       cmd_a = 16'hFFFF;
        default: cmd_a = W'($urandom);
      endcase
      msk   = (32'h1 << $urandom_range(0, W)) - 32'h1;
      cmd_b = W'($urandom & msk);
      rsp_ready = ($urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    c = 0;
    while (m_phase != 0 && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk("final idle", 32'(cmd_ready), 32'd1);
    chk("random responses seen", 32'(resp_cnt >= 40), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alsu_seq_ctrl.md
ALSU_SEQ_CTRL -- requirements
Module: alsu_seq_ctrl

Interface
REQ-001 Parameter BUS_WIDTH, default 16, datapath width; shift-amount width SAW = log2(BUS_WIDTH), 4 at default.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when both high.
REQ-005 cmd_op  in  2  00 SHLV, 01 SHRV, 10 MUL, 11 reserved.
REQ-006 cmd_a, cmd_b  in  BUS_WIDTH each  operands; SHLV/SHRV use cmd_b[SAW-1:0] as shift count n.
REQ-007 rsp_valid  out  1; rsp_ready  in  1; response consumed when both high.
REQ-008 rsp_result  out  BUS_WIDTH; rsp_zero  out  1; rsp_err  out  1.
REQ-009 alu_Op  out  3; alu_A, alu_B  out  BUS_WIDTH; alus_result  in  BUS_WIDTH; zero_flag  in  1 -- port to the shared ALSU (000 ADD, 110 SLL by 1, 111 SRL by 1).
REQ-010 busy  out  1  high in any state other than IDLE.

Function
REQ-011 FSM states: IDLE, SHIFT, MUL_ADD, MUL_SHIFT, DONE; cmd_ready = (state == IDLE).
REQ-012 Acceptance in IDLE (cycle 0) latches op, acc = cmd_a, cnt = n (shifts), or prod = 0, m = cmd_a, q = cmd_b (MUL).
REQ-013 SHLV/SHRV, n > 0: SHIFT for cycles 1..n, driving alu_Op = 110/111, alu_A = acc, alu_B = 0; each cycle acc <= alus_result, cnt decrements; DONE in cycle n+1.
REQ-014 SHLV/SHRV, n = 0: IDLE -> DONE directly; rsp_result = cmd_a in cycle 1.
REQ-015 MUL: MUL_ADD drives 000, A = prod, B = q[0] ? m : 0, prod <= alus_result; MUL_SHIFT drives 110, A = m, m <= alus_result, q <= q >> 1 internally; after MUL_SHIFT, go to MUL_ADD if the new q != 0, else DONE.
REQ-016 MUL latency: DONE in cycle 2k+1, where k = index of the highest set bit of cmd_b plus 1; cmd_b = 0 goes to DONE in cycle 1 with result 0.
REQ-017 MUL result is the low BUS_WIDTH bits of cmd_a*cmd_b; overflow is silently discarded.
REQ-018 rsp_zero equals zero_flag sampled on the final ALSU cycle; for no-ALSU paths (n = 0, b = 0, error) it equals (rsp_result == 0).
REQ-019 cmd_op = 11: DONE in cycle 1, rsp_result = 0, rsp_zero = 1, rsp_err = 1; otherwise rsp_err = 0.
REQ-020 DONE: rsp_valid = 1, with rsp_result/rsp_zero/rsp_err held stable until rsp_ready; on handshake go to IDLE; the next command is accepted no earlier than the following cycle.
REQ-021 In IDLE and DONE: alu_Op = 000, alu_A = alu_B = 0.
REQ-022 cmd_valid outside IDLE is ignored; no queueing.

Reset
REQ-023 rst_n low asynchronously forces IDLE and clears all registers; rsp_valid = 0, rsp_result = 0, rsp_zero = 0, rsp_err = 0, busy = 0, alu outputs 0, cmd_ready = 1.
REQ-024 Reset mid-operation abandons the command; no response is produced for it.

Configuration
REQ-025 Macro ALSU_SEQ_MUL_EN: defined -> MUL per REQ-015..017; undefined -> MUL states and m/q/prod registers are absent and cmd_op = 10 behaves as REQ-019 (err = 1, latency 1).

Structure
REQ-026 Shared package holds the cmd_op encodings, the FSM state enum, and the ALSU opcode constants (ADD 000, SLL 110, SRL 111).
REQ-027 No sub-module; the ALSU is instantiated by the parent and shared through REQ-009 ports.

Verification
REQ-028 SHLV a=0x0001 b=4 -> rsp_valid in cycle 5, result 0x0010, zero 0, err 0; SHRV a=0x8000 b=15 -> cycle 16, result 0x0001.
REQ-029 SHLV a=0x8000 b=1 -> result 0x0000, zero 1; SHLV a=0xABCD b=0 -> cycle 1, result 0xABCD.
REQ-030 MUL a=0x0003 b=0x0005 -> cycle 7, result 0x000F; MUL a=0x1234 b=0 -> cycle 1, result 0, zero 1; MUL a=0x0100 b=0x0100 -> result 0x0000, zero 1.
REQ-031 rsp_ready held low 3 cycles in DONE with cmd_valid high -> response stable, cmd_ready 0, no command accepted; accepted the cycle after the handshake.
REQ-032 rst_n pulsed low in cycle 3 of SHLV b=8 -> rsp_valid never rises, cmd_ready 1 immediately; the next SHLV a=1 b=2 returns 0x0004.
REQ-033 cmd_op=11 -> err 1, result 0; with ALSU_SEQ_MUL_EN undefined, cmd_op=10 -> err 1, cycle 1.
